// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Drives the layer-00 convolution pipeline across NUM_GROUPS groups of four
//   filters. For each group it requests a weight/bias load, pulses the pipeline
//   start, then collects BEATS_PER_FRAME packed result beats into the output
//   buffer at linear addresses (group*BEATS_PER_FRAME + beat). The datapath
//   cannot be stalled, so dropped or unexpected beats raise a sticky o_err.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_start, i_abort  start a pass (IDLE only) / return to IDLE from anywhere
//   o_busy, o_done    not-IDLE level / one-cycle end-of-pass pulse
//   o_err             sticky dropped/unexpected beat flag, cleared by a new pass
//   o_group_idx       current group (weight bank / bias set select)
//   o_wload_req       weight load request level, i_wload_ack completes it
//   o_pipe_start      one-cycle datapath start pulse
//   i_res_vld/_data   result beat from the datapath, {f3,f2,f1,f0}
//   i_obuf_ready      output buffer can take a write this cycle
//   o_wr_en/_addr/_data  registered output buffer write port
module layer_sequencer #(
  parameter int NUM_GROUPS      = 4,
  parameter int BEATS_PER_FRAME = 64,
  parameter int GROUP_W         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  parameter int ADDR_W          = $clog2(NUM_GROUPS * BEATS_PER_FRAME)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_abort,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [GROUP_W-1:0]  o_group_idx,
  output logic                o_wload_req,
  input  logic                i_wload_ack,
  output logic                o_pipe_start,
  input  logic                i_res_vld,
  input  logic [31:0]         i_res_data,
  input  logic                i_obuf_ready,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [31:0]         o_wr_data
);

  localparam int BEAT_W = $clog2(BEATS_PER_FRAME);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS_PER_FRAME - 1);
  localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    START,
    RUN
  } state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [ADDR_W-1:0]   beat_addr;

  always_comb begin
    beat_addr = ADDR_W'(o_group_idx) * ADDR_W'(BEATS_PER_FRAME) + ADDR_W'(beat_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      o_group_idx  <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_wload_req  <= 1'b0;
      o_pipe_start <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
    end else begin
      o_done       <= 1'b0;
      o_pipe_start <= 1'b0;
      o_wr_en      <= 1'b0;

      if (i_abort) begin
        // Any beat in the abort cycle is discarded silently; o_err is kept.
        state       <= IDLE;
        beat_cnt    <= '0;
        o_group_idx <= '0;
        o_busy      <= 1'b0;
        o_wload_req <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start) begin
              state       <= LOAD_W;
              o_busy      <= 1'b1;
              o_wload_req <= 1'b1;
              o_err       <= 1'b0;
              o_group_idx <= '0;
              beat_cnt    <= '0;
            end
            // A stray beat is flagged even when it coincides with a new start.
            if (i_res_vld) o_err <= 1'b1;
          end

          LOAD_W: begin
            if (i_res_vld) o_err <= 1'b1;
            if (i_wload_ack) begin
              state        <= START;
              o_wload_req  <= 1'b0;
              o_pipe_start <= 1'b1;
            end
          end

          START, RUN: begin
            state <= RUN;
            if (i_res_vld) begin
              if (i_obuf_ready) begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= beat_addr;
                o_wr_data <= i_res_data;
              end else begin
                o_err <= 1'b1;
              end
              if (beat_cnt == LAST_BEAT) begin
                beat_cnt <= '0;
                if (o_group_idx == LAST_GROUP) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                end else begin
                  o_group_idx <= o_group_idx + 1'b1;
                  state       <= LOAD_W;
                  o_wload_req <= 1'b1;
                end
              end else begin
                beat_cnt <= beat_cnt + 1'b1;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Testbench for layer_sequencer with NUM_GROUPS=2, BEATS_PER_FRAME=4.
// A hand-written vector table covers one clean pass; directed passes cover
// drops, stray beats, abort, held start with same-cycle ack and mid-pass
// reset; a random phase finishes. Every cycle is also checked against a
// pass-level reference model that tracks beats consumed as one linear index.
module tb_layer_sequencer;
  localparam int G  = 2;
  localparam int B  = 4;
  localparam int GW = 1;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, i_start, i_abort, i_wload_ack, i_res_vld, i_obuf_ready;
  logic [31:0]   i_res_data;
  logic          o_busy, o_done, o_err, o_wload_req, o_pipe_start, o_wr_en;
  logic [GW-1:0] o_group_idx;
  logic [AW-1:0] o_wr_addr;
  logic [31:0]   o_wr_data;

  always #5 clk = ~clk;

  layer_sequencer #(.NUM_GROUPS(G), .BEATS_PER_FRAME(B)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_group_idx(o_group_idx),
    .o_wload_req(o_wload_req), .i_wload_ack(i_wload_ack), .o_pipe_start(o_pipe_start),
    .i_res_vld(i_res_vld), .i_res_data(i_res_data), .i_obuf_ready(i_obuf_ready),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pass is a run of G*B beats indexed linearly.
  bit          m_busy, m_load, m_done, m_err, m_ps, m_we, m_adv;
  int          m_lin;
  logic [31:0] m_addr, m_data;

  task automatic model_update();
    m_done = 0; m_ps = 0; m_we = 0; m_adv = 0;
    if (rst) begin
      m_busy = 0; m_load = 0; m_err = 0; m_lin = 0;
      m_addr = 0; m_data = 0; m_adv = 1;
    end else if (i_abort) begin
      m_busy = 0; m_load = 0; m_lin = 0;
    end else if (!m_busy) begin
      if (i_start) begin
        m_busy = 1; m_load = 1; m_lin = 0; m_err = 0;
      end
      if (i_res_vld) m_err = 1;
    end else if (m_load) begin
      if (i_res_vld) m_err = 1;
      if (i_wload_ack) begin
        m_load = 0; m_ps = 1;
      end
    end else if (i_res_vld) begin
      if (i_obuf_ready) begin
        m_we = 1; m_adv = 1; m_addr = m_lin; m_data = i_res_data;
      end else begin
        m_err = 1;
      end
      m_lin++;
      if (m_lin % B == 0) begin
        if (m_lin == G * B) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_load = 1;
        end
      end
    end
  endtask

  // Apply current inputs for one clock, then compare after the edge.
  task automatic step();
    int g;
    model_update();
    @(posedge clk);
    #1;
    g = m_lin / B;
    if (g > G - 1) g = G - 1;
    chk("busy",       o_busy,       m_busy);
    chk("done",       o_done,       m_done);
    chk("err",        o_err,        m_err);
    chk("group_idx",  o_group_idx,  g);
    chk("wload_req",  o_wload_req,  m_busy && m_load);
    chk("pipe_start", o_pipe_start, m_ps);
    chk("wr_en",      o_wr_en,      m_we);
    if (m_adv) begin
      chk("wr_addr", o_wr_addr, m_addr);
      chk("wr_data", o_wr_data, m_data);
    end
  endtask

  task automatic quiet();
    rst = 0; i_start = 0; i_abort = 0; i_wload_ack = 0;
    i_res_vld = 0; i_obuf_ready = 1; i_res_data = '0;
  endtask

  typedef struct {
    logic          rst, start, abort, ack, vld, ready;
    logic [31:0]   data;
    logic          busy, done, err, wreq, ps, we;
    logic [GW-1:0] grp;
    logic [AW-1:0] addr;
  } vec_t;

  // in = {rst,start,abort,ack,vld,ready}, out = {busy,done,err,wreq,ps,we}
  function automatic vec_t mk(input bit [5:0] in, input int d, input bit [5:0] out,
                              input int grp, input int addr);
    vec_t v;
    {v.rst, v.start, v.abort, v.ack, v.vld, v.ready} = in;
    {v.busy, v.done, v.err, v.wreq, v.ps, v.we} = out;
    v.data = 32'(d);
    v.grp  = GW'(grp);
    v.addr = AW'(addr);
    return v;
  endfunction

  // Drives one pass reacting to DUT handshakes; knobs select the corner case.
  task automatic run_pass(input int drop_at, input int abort_at,
                          input bit hold_start, input bit fast_ack);
    int beats = 0;
    int guard = 0;
    int ackwait = 0;
    if (!o_busy) begin
      i_start = 1;
      step();
      if (!hold_start) i_start = 0;
    end
    while (o_busy && guard < 200) begin
      guard++;
      i_wload_ack = 0; i_res_vld = 0; i_obuf_ready = 1; i_abort = 0;
      if (o_wload_req) begin
        if (fast_ack || ackwait == 2) begin
          i_wload_ack = 1; ackwait = 0;
        end else ackwait++;
      end else if (beats == abort_at) begin
        i_abort = 1; i_res_vld = 1; i_res_data = 32'hDEAD_BEEF;
        beats++;
      end else if ($urandom_range(0, 2) != 0) begin
        i_res_vld  = 1;
        i_res_data = 32'(beats);
        if (beats == drop_at) i_obuf_ready = 0;
        beats++;
      end
      step();
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL pass_timeout: busy still %0b after %0d cycles, required 0", o_busy, guard);
    end
    i_abort = 0; i_res_vld = 0; i_wload_ack = 0; i_obuf_ready = 1;
  endtask

  vec_t tbl[18];

  initial begin
    tbl[0]  = mk(6'b100000, 0, 6'b000000, 0, 0);
    tbl[1]  = mk(6'b010000, 0, 6'b100100, 0, 0);
    tbl[2]  = mk(6'b000000, 0, 6'b100100, 0, 0);
    tbl[3]  = mk(6'b000100, 0, 6'b100010, 0, 0);
    tbl[4]  = mk(6'b000000, 0, 6'b100000, 0, 0);
    tbl[5]  = mk(6'b000011, 0, 6'b100001, 0, 0);
    tbl[6]  = mk(6'b000001, 0, 6'b100000, 0, 0);
    tbl[7]  = mk(6'b000011, 1, 6'b100001, 0, 1);
    tbl[8]  = mk(6'b000011, 2, 6'b100001, 0, 2);
    tbl[9]  = mk(6'b000001, 0, 6'b100000, 0, 0);
    tbl[10] = mk(6'b000011, 3, 6'b100101, 1, 3);
    tbl[11] = mk(6'b000101, 0, 6'b100010, 1, 0);
    tbl[12] = mk(6'b000011, 4, 6'b100001, 1, 4);
    tbl[13] = mk(6'b000011, 5, 6'b100001, 1, 5);
    tbl[14] = mk(6'b000001, 0, 6'b100000, 1, 0);
    tbl[15] = mk(6'b000011, 6, 6'b100001, 1, 6);
    tbl[16] = mk(6'b000011, 7, 6'b010001, 1, 7);
    tbl[17] = mk(6'b000001, 0, 6'b000000, 1, 0);

    quiet();
    #2;
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; i_start = tbl[i].start; i_abort = tbl[i].abort;
      i_wload_ack = tbl[i].ack; i_res_vld = tbl[i].vld; i_obuf_ready = tbl[i].ready;
      i_res_data = tbl[i].data;
      step();
      chk("tbl_busy",  o_busy,       tbl[i].busy);
      chk("tbl_done",  o_done,       tbl[i].done);
      chk("tbl_err",   o_err,        tbl[i].err);
      chk("tbl_grp",   o_group_idx,  tbl[i].grp);
      chk("tbl_wreq",  o_wload_req,  tbl[i].wreq);
      chk("tbl_ps",    o_pipe_start, tbl[i].ps);
      chk("tbl_we",    o_wr_en,      tbl[i].we);
      if (tbl[i].we || tbl[i].rst) begin
        chk("tbl_addr", o_wr_addr, tbl[i].addr);
        chk("tbl_data", o_wr_data, tbl[i].data);
      end
    end
    quiet();

    // Dropped beat 2 of group 0: sticky error through the end of the pass.
    run_pass(2, -1, 0, 0);
    chk("drop_err_sticky", o_err, 1);
    i_start = 1; step(); i_start = 0;
    chk("start_clears_err", o_err, 0);
    run_pass(-1, -1, 0, 0);

    // Stray beats in IDLE and in LOAD_W, then a clean pass from address 0.
    i_res_vld = 1; step(); i_res_vld = 0;
    chk("idle_beat_err", o_err, 1);
    chk("idle_beat_no_wr", o_wr_en, 0);
    i_start = 1; step(); i_start = 0;
    i_res_vld = 1; step(); i_res_vld = 0;
    chk("loadw_beat_err", o_err, 1);
    chk("loadw_beat_no_wr", o_wr_en, 0);
    run_pass(-1, -1, 0, 0);

    // Abort after two beats of group 1 (beat index 6), then a fresh pass.
    run_pass(-1, 6, 0, 0);
    chk("abort_idle", o_busy, 0);
    chk("abort_no_done", o_done, 0);
    run_pass(-1, -1, 0, 0);

    // Start held for the whole pass, ack on the first cycle of each request.
    run_pass(-1, -1, 1, 1);
    i_start = 1; step(); i_start = 0;
    chk("restart_on_done", o_busy, 1);
    i_abort = 1; step(); i_abort = 0;

    // Reset in the middle of a weight load.
    i_start = 1; step(); i_start = 0;
    step();
    rst = 1; step(); rst = 0;
    chk("rst_busy", o_busy, 0);
    chk("rst_wreq", o_wload_req, 0);
    chk("rst_addr", o_wr_addr, 0);

    // Random phase.
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      i_abort      = ($urandom_range(0, 99) == 0);
      i_start      = ($urandom_range(0, 7) == 0);
      i_wload_ack  = ($urandom_range(0, 2) == 0);
      i_res_vld    = ($urandom_range(0, 1) == 0);
      i_obuf_ready = ($urandom_range(0, 7) != 0);
      i_res_data   = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Sequences the layer-00 convolution pipeline over several 4-filter output groups. For each group it requests a weight/bias load, pulses the pipeline start, and collects the packed 32-bit result beats (four 8-bit filter outputs per beat) into an output buffer at linear addresses. It sits between the top-level network control and the parsing / weight_ctrl / mac_bank / adder_tree2 / additional_layer00 datapath. The datapath cannot stall, so the sequencer reports dropped beats through a sticky error flag.

## Interface
- NUM_GROUPS, 4: number of 4-filter groups per layer pass (≥1)
- BEATS_PER_FRAME, 64: result beats expected per group (≥2)
- GROUP_W, $clog2(NUM_GROUPS) (min 1): group index width
- ADDR_W, $clog2(NUM_GROUPS*BEATS_PER_FRAME): output buffer address width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  start a layer pass; honoured only in IDLE
- i_abort  in  1  return to IDLE from any state
- o_busy  out  1  high in every state other than IDLE
- o_done  out  1  one-cycle pulse when the last beat of the last group is written
- o_err  out  1  sticky flag: a beat was dropped or arrived unexpectedly
- o_group_idx  out  GROUP_W  current group; selects the weight bank and bias set
- o_wload_req  out  1  weight/bias load request; level signal
- i_wload_ack  in  1  load complete; sampled only while o_wload_req=1
- o_pipe_start  out  1  one-cycle start pulse to the datapath
- i_res_vld  in  1  result beat valid from the datapath
- i_res_data  in  32  packed {f3,f2,f1,f0} result beat
- i_obuf_ready  in  1  output buffer can accept a write this cycle
- o_wr_en, o_wr_addr[ADDR_W], o_wr_data[32]  out  registered output buffer write port

## Operation
- States:
  - IDLE → LOAD_W on i_start.
  - LOAD_W → START when i_wload_ack=1.
  - START → RUN unconditionally.
  - RUN → LOAD_W on the last beat of a non-final group.
  - RUN → IDLE on the last beat of the final group.
- i_abort has priority over every transition. On abort:
  - next state is IDLE, and group and beat counters clear;
  - o_done is not asserted, and any beat arriving in the abort cycle is dropped (no o_wr_en, no o_err).
- i_start is ignored while o_busy=1. An accepted i_start clears o_err, o_group_idx and the beat counter.
- Beat acceptance: a beat with i_res_vld=1 in START or RUN increments the beat counter.
  - If i_obuf_ready=1, the beat is written.
  - If i_obuf_ready=0, the beat is dropped, the counter still advances, and o_err is set.
- i_res_vld=1 in IDLE or LOAD_W sets o_err. The beat is discarded and the counter is unchanged.
- Address: o_wr_addr = o_group_idx*BEATS_PER_FRAME + beat_cnt, using the values sampled with the beat. o_wr_data = i_res_data unmodified.
- Last beat is beat_cnt == BEATS_PER_FRAME-1 with i_res_vld=1. On it:
  - beat_cnt wraps to 0;
  - o_group_idx increments, or holds if the group is final.
- Reset values:
  - state IDLE, counters 0;
  - o_busy, o_done, o_err, o_wload_req, o_pipe_start, o_wr_en all 0;
  - o_wr_addr and o_wr_data are 0.

## Timing
- All outputs are registered.
- i_start at cycle t → o_busy=1 and o_wload_req=1 at t+1.
- i_wload_ack at cycle a (with o_wload_req=1) → o_wload_req=0 and o_pipe_start=1 at a+1 → RUN at a+2. o_pipe_start is exactly one cycle wide.
- i_wload_ack arriving in the same cycle that o_wload_req first rises is valid.
- Beat at cycle v → o_wr_en=1 with address and data at v+1.
- Last beat of a non-final group at v:
  - o_group_idx updates at v+1;
  - o_wload_req=1 at v+1.
- Last beat of the final group at v:
  - o_wr_en=1, o_done=1 and o_busy=0 all at v+1;
  - a new i_start is accepted at v+1.
- Between groups: o_wload_req must not be asserted while the datapath is still emitting beats. This is guaranteed because the group transition happens only on the last beat.
- rst asserted mid-pass → all outputs at their reset values on the next edge. No write or done is issued.

## Test plan
- NUM_GROUPS=2, BEATS_PER_FRAME=4, ack 2 cycles after req, 8 beats 0x00000000..0x00000007 with gaps → writes to addresses 0..7 in order with matching data; two o_pipe_start pulses; o_done once, coincident with the addr-7 write; o_err=0.
- Same config, i_obuf_ready=0 during beat 2 of group 0 → no write to address 2; o_err=1 and held; remaining addresses written correctly; o_done still pulses; next i_start clears o_err.
- i_res_vld=1 in IDLE and again in LOAD_W → o_err=1; no o_wr_en; beat counter unaffected (first RUN beat writes address 0).
- i_abort during RUN after 2 beats of group 1 → IDLE next cycle, o_busy=0, no o_done; a following pass restarts at group 0, address 0.
- i_start held high for an entire pass, plus i_wload_ack asserted in the same cycle as o_wload_req first rises → only one pass per IDLE entry; o_pipe_start exactly 1 cycle after the ack; a second pass starts the cycle o_done is seen.
- rst pulsed mid-LOAD_W with o_wload_req=1 → all outputs 0 on the next edge; state IDLE.
